// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch front-end.
package riscv_pkg;

  localparam int INST_BYTES  = 4;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  // Queue occupancy after one edge of push/pop activity.
  function automatic logic [1:0] count_after(input logic [1:0] count,
                                             input logic push,
                                             input logic pop);
    return count + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {addr, inst}; slot0 is always the head.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int INSTSIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [WORDSIZE-1:0] push_addr,
  input  logic [INSTSIZE-1:0] push_inst,
  output logic [1:0]          count,
  output logic                head_valid,
  output logic [WORDSIZE-1:0] head_addr,
  output logic [INSTSIZE-1:0] head_inst
);

  logic [WORDSIZE-1:0] slot0_addr, slot1_addr;
  logic [INSTSIZE-1:0] slot0_inst, slot1_inst;
  logic                push_ok, pop_ok;

  assign push_ok    = push && (count != 2'(FETCH_DEPTH));
  assign pop_ok     = pop && (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head_addr  = slot0_addr;
  assign head_inst  = slot0_inst;

  // Flush only clears occupancy; stale slot contents are never exposed as valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= 2'd0;
      slot0_addr <= '0;
      slot0_inst <= '0;
      slot1_addr <= '0;
      slot1_inst <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            slot0_addr <= push_addr;
            slot0_inst <= push_inst;
          end else begin
            slot1_addr <= push_addr;
            slot1_inst <= push_inst;
          end
        end
        2'b01: begin
          slot0_addr <= slot1_addr;
          slot0_inst <= slot1_inst;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0_addr <= push_addr;
            slot0_inst <= push_inst;
          end else begin
            slot0_addr <= slot1_addr;
            slot0_inst <= slot1_inst;
            slot1_addr <= push_addr;
            slot1_inst <= push_inst;
          end
        end
        default: ;
      endcase
      count <= count_after(count, push_ok, pop_ok);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front-end: requests words at the PC, queues them, and advances the PC
// only for responses actually accepted.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int INSTSIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORDSIZE-1:0] pc_addr,
  output logic [WORDSIZE-1:0] increment,
  output logic                mem_req,
  output logic [WORDSIZE-1:0] mem_addr,
  input  logic                mem_ready,
  input  logic [INSTSIZE-1:0] mem_rdata,
  input  logic                flush,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INSTSIZE-1:0] inst,
  output logic [WORDSIZE-1:0] inst_addr,
  output logic [1:0]          fetch_state
);

  // Handshakes: a memory transfer happens on an edge where mem_req && mem_ready;
  // a decode transfer happens on an edge where inst_valid && inst_ready. mem_req
  // and mem_addr stay constant until their transfer; flush cancels both.
  fetch_state_t state_q;
  logic         mem_req_q;
  logic         accept;
  logic         pop;
  logic [1:0]   count;
  logic [1:0]   count_next;

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_addr;
  assign accept      = mem_req_q && mem_ready && !flush;
  assign pop         = inst_valid && inst_ready;
  assign count_next  = count_after(count, accept, pop);
  assign increment   = accept ? WORDSIZE'(INST_BYTES) : '0;
  assign fetch_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
    end else if (flush) begin
      state_q   <= FETCH;
      mem_req_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q   <= FETCH;
          mem_req_q <= 1'b1;
        end
        FETCH: begin
          if (accept && (count_next == 2'(FETCH_DEPTH))) begin
            state_q   <= FULL;
            mem_req_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            state_q   <= FETCH;
            mem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .WORDSIZE(WORDSIZE),
    .INSTSIZE(INSTSIZE)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .pop       (pop),
    .flush     (flush),
    .push_addr (pc_addr),
    .push_inst (mem_rdata),
    .count     (count),
    .head_valid(inst_valid),
    .head_addr (inst_addr),
    .head_inst (inst)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC model and a wait-state memory model.
module tb_instruction_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic [63:0] pc_addr;
  logic [63:0] increment;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic [1:0]  fetch_state;

  int checks   = 0;
  int failures = 0;
  int mem_wait = 0;
  int wait_cnt;

  instruction_fetch #(.WORDSIZE(64), .INSTSIZE(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .increment  (increment),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_addr  (inst_addr),
    .fetch_state(fetch_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // program counter model: flush redirects to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     pc_addr <= 64'd0;
    else if (flush) pc_addr <= 64'd0;
    else            pc_addr <= pc_addr + increment;
  end

  // memory model with mem_wait wait cycles per request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              wait_cnt <= 0;
    else if (flush || !mem_req || mem_ready) wait_cnt <= 0;
    else                                     wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    mem_ready = mem_req && (wait_cnt >= mem_wait);
    mem_rdata = mem_addr[31:0] ^ K;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic        fl;
    logic        req;
    logic [63:0] addr;
    logic [63:0] inc;
    logic        valid;
    logic [31:0] inst;
    logic [63:0] iaddr;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // rows: inst_ready, flush -> mem_req, mem_addr, increment, inst_valid, inst, inst_addr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'd0,  64'd0, 1'b0, 32'd0,         64'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 64'd0,  64'd4, 1'b0, 32'd0,         64'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 64'd4,  64'd4, 1'b1, K,             64'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 64'd8,  64'd4, 1'b1, K | 32'h04,    64'd4};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 64'd12, 64'd4, 1'b1, K | 32'h08,    64'd8};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 64'd16, 64'd4, 1'b1, K | 32'h0C,    64'd12};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 64'd20, 64'd4, 1'b1, K | 32'h10,    64'd16};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'd24, 64'd0, 1'b1, K | 32'h10,    64'd16};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 64'd24, 64'd0, 1'b1, K | 32'h10,    64'd16};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 64'd24, 64'd0, 1'b1, K | 32'h10,    64'd16};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 64'd24, 64'd4, 1'b1, K | 32'h14,    64'd20};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 64'd28, 64'd0, 1'b1, K | 32'h14,    64'd20};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 64'd0,  64'd4, 1'b0, 32'd0,         64'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 64'd4,  64'd4, 1'b1, K,             64'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 64'd8,  64'd0, 1'b1, K,             64'd0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 64'd8,  64'd0, 1'b1, K,             64'd0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 64'd8,  64'd0, 1'b1, K | 32'h04,    64'd4};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 64'd0,  64'd4, 1'b0, 32'd0,         64'd0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 64'd4,  64'd4, 1'b1, K,             64'd0};

    reset      = 1'b1;
    flush      = 1'b0;
    inst_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("reset_req",   64'(mem_req), 64'd0);
    check("reset_inc",   increment, 64'd0);
    check("reset_valid", 64'(inst_valid), 64'd0);
    check("reset_inst",  64'(inst), 64'd0);
    check("reset_iaddr", inst_addr, 64'd0);
    check("reset_state", 64'(fetch_state), 64'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // zero-wait streaming, back-pressure to FULL, flushes
    for (int i = 0; i < 19; i++) begin
      inst_ready = vecs[i].ir;
      flush      = vecs[i].fl;
      #1;
      check($sformatf("row%0d_req", i),   64'(mem_req), 64'(vecs[i].req));
      check($sformatf("row%0d_addr", i),  mem_addr, vecs[i].addr);
      check($sformatf("row%0d_inc", i),   increment, vecs[i].inc);
      check($sformatf("row%0d_valid", i), 64'(inst_valid), 64'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("row%0d_inst", i),  64'(inst), 64'(vecs[i].inst));
        check($sformatf("row%0d_iaddr", i), inst_addr, vecs[i].iaddr);
      end
      @(negedge clk);
    end

    // three wait cycles after a clearing flush
    mem_wait   = 3;
    flush      = 1'b1;
    inst_ready = 1'b0;
    #1 check("wait_flush_inc", increment, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("wait_state", 64'(fetch_state), 64'(FETCH));
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("wait%0d_req", k),   64'(mem_req), 64'd1);
      check($sformatf("wait%0d_addr", k),  mem_addr, 64'd0);
      check($sformatf("wait%0d_inc", k),   increment, (k == 3) ? 64'd4 : 64'd0);
      check($sformatf("wait%0d_valid", k), 64'(inst_valid), 64'd0);
      @(negedge clk);
    end
    #1;
    check("wait_done_valid", 64'(inst_valid), 64'd1);
    check("wait_done_inst",  64'(inst), 64'(K));
    check("wait_done_iaddr", inst_addr, 64'd0);
    check("wait_done_addr",  mem_addr, 64'd4);
    check("wait_done_inc",   increment, 64'd0);

    // asynchronous reset in the middle of a waiting request
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_req",   64'(mem_req), 64'd0);
    check("areset_inc",   increment, 64'd0);
    check("areset_valid", 64'(inst_valid), 64'd0);
    check("areset_inst",  64'(inst), 64'd0);
    check("areset_iaddr", inst_addr, 64'd0);
    check("areset_addr",  mem_addr, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("release_c1_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    #1;
    check("release_c2_req",  64'(mem_req), 64'd1);
    check("release_c2_addr", mem_addr, 64'd0);
    check("release_c2_inc",  increment, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
